mem_cmd_sequencer: RTL and testbench

Upstream request front-end for the 8x8 memory unit. Accepts read and write requests over a valid/ready handshake and buffers them in a 2-entry queue. Converts each request into the op/select/adr/in command sequence the memory unit's FSM expects, with fixed hold times and a mandatory idle gap between accesses. Captures read data from the unit's out bus and returns it on a valid/ready response channel.

---
 rtl/mem_seq_pkg.sv | 33 +++
 rtl/mem_cmd_sequencer_fifo.sv | 66 ++++++
 rtl/mem_cmd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_mem_cmd_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types, command encodings and default widths for the memory command sequencer.
package mem_seq_pkg;

   localparam int ADDR_W_DEF   = 3;
   localparam int DATA_W_DEF   = 8;
   localparam int WR_HOLD_DEF  = 2;
   localparam int RD_HOLD_DEF  = 2;
   localparam int GAP_HOLD_DEF = 2;
   localparam int QDEPTH_DEF   = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_GAP
   } state_e;

   typedef struct packed {
      logic op;
      logic select;
   } cmd_t;

   localparam cmd_t CMD_IDLE  = cmd_t'(2'b00);
   localparam cmd_t CMD_WRITE = cmd_t'(2'b11);
   localparam cmd_t CMD_READ  = cmd_t'(2'b01);

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/mem_cmd_sequencer_fifo.sv
// Request queue: power-of-two deep FIFO with wrap-around pointers, occupancy count and full/empty flags.
module req_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_cmd_sequencer.sv
// Front-end that turns queued read/write requests into timed op/select/adr/in
// command sequences for the 8x8 memory unit and returns read data on a response channel.
module mem_cmd_sequencer
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WR_HOLD  = WR_HOLD_DEF,
   parameter int RD_HOLD  = RD_HOLD_DEF,
   parameter int GAP_HOLD = GAP_HOLD_DEF,
   parameter int QDEPTH   = QDEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_adr,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_adr,
   output logic              op,
   output logic              select,
   output logic [ADDR_W-1:0] adr,
   output logic [DATA_W-1:0] in,
   input  logic [DATA_W-1:0] out,
   input  logic              mem_valid,
   output logic              err
);

   localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(max3(WR_HOLD, RD_HOLD, GAP_HOLD)) + 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   cmd_t              cmd_d;
   logic              op_q, op_d;
   logic              select_q, select_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] in_q, in_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [ADDR_W-1:0] rsp_adr_q, rsp_adr_d;
   logic              err_q, err_d;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_wdata;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic               head_write;
   logic [ADDR_W-1:0]  head_adr;
   logic [DATA_W-1:0]  head_data;
   logic               hold_last;
   logic               access_last;

   assign req_ready  = ~fifo_full;
   assign fifo_push  = req_valid & req_ready;
   assign fifo_wdata = {req_write, req_adr, req_data};
   assign {head_write, head_adr, head_data} = fifo_rdata;

   req_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (ENTRY_W)
   ) u_req_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The hold counter is loaded on entry to a timed state; that state ends when it reads 1.
   assign hold_last   = (cnt_q == CNT_W'(1));
   assign access_last = hold_last & ((state_q == S_WRITE) | (state_q == S_READ));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= 1'b0;
         select_q    <= 1'b0;
         adr_q       <= '0;
         in_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_adr_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         select_q    <= select_d;
         adr_q       <= adr_d;
         in_q        <= in_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_adr_q   <= rsp_adr_d;
         err_q       <= err_d;
      end
   end

   // A read at the head waits while a response is still pending; nothing behind it may overtake.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fifo_pop = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               if (head_write) begin
                  fifo_pop = 1'b1;
                  state_d  = S_WRITE;
                  cnt_d    = CNT_W'(WR_HOLD);
               end else if (!rsp_valid_q) begin
                  fifo_pop = 1'b1;
                  state_d  = S_READ;
                  cnt_d    = CNT_W'(RD_HOLD);
               end
            end
         end
         S_WRITE, S_READ: begin
            if (hold_last) begin
               state_d = S_GAP;
               cnt_d   = CNT_W'(GAP_HOLD);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_GAP: begin
            if (hold_last) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Mem-side outputs are registered from the next state, so they line up with the state register.
   always_comb begin
      case (state_d)
         S_WRITE: cmd_d = CMD_WRITE;
         S_READ:  cmd_d = CMD_READ;
         default: cmd_d = CMD_IDLE;
      endcase
      op_d     = cmd_d.op;
      select_d = cmd_d.select;
      adr_d    = adr_q;
      in_d     = in_q;
      if (fifo_pop) begin
         adr_d = head_adr;
         if (head_write) begin
            in_d = head_data;
         end
      end
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_adr_d   = rsp_adr_q;
      if (access_last && (state_q == S_READ)) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = out;
         rsp_adr_d   = adr_q;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      err_d = err_q | (access_last & ~mem_valid);
   end

   assign op        = op_q;
   assign select    = select_q;
   assign adr       = adr_q;
   assign in        = in_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_adr   = rsp_adr_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Self-checking bench: transaction-timeline model of the sequencer plus directed scenarios with literal expectations.
module tb_mem_cmd_sequencer;

   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 8;
   localparam int WR_HOLD  = 2;
   localparam int RD_HOLD  = 2;
   localparam int GAP_HOLD = 2;
   localparam int QDEPTH   = 2;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_write = 1'b0;
   logic [ADDR_W-1:0] req_adr   = '0;
   logic [DATA_W-1:0] req_data  = '0;
   logic              rsp_ready = 1'b0;
   logic              mem_valid = 1'b1;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] rsp_adr;
   logic              op;
   logic              select;
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] in_bus;
   logic [DATA_W-1:0] mem_out;
   logic              err;

   int checks    = 0;
   int errors    = 0;
   int op_cycles = 0;

   always #5 clk = ~clk;

   mem_cmd_sequencer #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .WR_HOLD  (WR_HOLD),
      .RD_HOLD  (RD_HOLD),
      .GAP_HOLD (GAP_HOLD),
      .QDEPTH   (QDEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_adr   (req_adr),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_adr   (rsp_adr),
      .op        (op),
      .select    (select),
      .adr       (adr),
      .in        (in_bus),
      .out       (mem_out),
      .mem_valid (mem_valid),
      .err       (err)
   );

   // Stand-in for the memory unit: stores while a write command is driven, reads combinationally.
   logic [DATA_W-1:0] emem [8] = '{default: 8'h00};
   assign mem_out = emem[adr];
   always @(negedge clk) begin
      if (op && select && mem_valid) emem[adr] <= in_bus;
   end

   always @(posedge clk) begin
      #1;
      if (op) op_cycles <= op_cycles + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each access occupies a fixed timeline measured in clock edges.
   typedef struct {
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } req_t;

   req_t              mq[$];
   req_t              m_cur;
   logic [DATA_W-1:0] mmem [8] = '{default: 8'h00};
   bit                m_active, m_rsp_valid, m_err;
   logic [DATA_W-1:0] m_rsp_data, m_in;
   logic [ADDR_W-1:0] m_rsp_adr, m_adr;
   int                edge_n = 0;
   int                m_end  = 0;
   int                m_free = 0;
   bit                s_rst, s_valid, s_write, s_rr, s_mv, pre_rsp;
   logic [ADDR_W-1:0] s_adr;
   logic [DATA_W-1:0] s_data;
   int                pre_size;

   always @(posedge clk) begin
      s_rst   = rst_n;
      s_valid = req_valid;
      s_write = req_write;
      s_adr   = req_adr;
      s_data  = req_data;
      s_rr    = rsp_ready;
      s_mv    = mem_valid;
      #1;
      edge_n++;
      if (!s_rst) begin
         mq.delete();
         m_active    = 0;
         m_rsp_valid = 0;
         m_rsp_data  = '0;
         m_rsp_adr   = '0;
         m_err       = 0;
         m_adr       = '0;
         m_in        = '0;
         m_free      = 0;
      end else begin
         pre_rsp  = m_rsp_valid;
         pre_size = mq.size();
         if (m_rsp_valid && s_rr) m_rsp_valid = 0;
         if (m_active && edge_n == m_end) begin
            m_active = 0;
            if (!s_mv) m_err = 1;
            if (m_cur.w) begin
               if (s_mv) mmem[m_cur.a] = m_cur.d;
            end else begin
               m_rsp_valid = 1;
               m_rsp_data  = mmem[m_cur.a];
               m_rsp_adr   = m_cur.a;
            end
         end
         if (pre_size > 0 && edge_n >= m_free && (mq[0].w || !pre_rsp)) begin
            m_cur    = mq.pop_front();
            m_active = 1;
            m_end    = edge_n + (m_cur.w ? WR_HOLD : RD_HOLD);
            m_free   = m_end + GAP_HOLD + 1;
            m_adr    = m_cur.a;
            if (m_cur.w) m_in = m_cur.d;
         end
         if (s_valid && pre_size < QDEPTH) mq.push_back('{w: s_write, a: s_adr, d: s_data});
      end
      checkOutput("op", op, m_active && m_cur.w);
      checkOutput("select", select, m_active);
      checkOutput("adr", adr, m_adr);
      if (m_active && m_cur.w) checkOutput("in", in_bus, m_in);
      checkOutput("rsp_valid", rsp_valid, m_rsp_valid);
      checkOutput("rsp_data", rsp_data, m_rsp_data);
      checkOutput("rsp_adr", rsp_adr, m_rsp_adr);
      checkOutput("req_ready", req_ready, mq.size() < QDEPTH);
      checkOutput("err", err, m_err);
   end

   task automatic applyStimulus(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bit   done;
      logic rdy;
      done      = 0;
      req_valid = 1'b1;
      req_write = w;
      req_adr   = a;
      req_data  = d;
      for (int k = 0; k < 200 && !done; k++) begin
         rdy = req_ready;
         @(posedge clk);
         if (rdy) done = 1;
         @(negedge clk);
      end
      req_valid = 1'b0;
      checkOutput("req_accepted", 32'(done), 1);
   endtask

   task automatic waitRsp(input int limit, output int lat);
      lat = 0;
      for (int k = 1; k <= limit; k++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      checkOutput("rsp_arrived", rsp_valid, 1);
      @(negedge clk);
   endtask

   task automatic consumeResponse();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         lat;
      int         base;
      int         rsp_seen;
      int         sel_seen;
      logic [7:0] pat;

      idle(3);
      checkOutput("reset_op", op, 0);
      checkOutput("reset_select", select, 0);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_err", err, 0);
      rst_n = 1'b1;
      idle(1);
      checkOutput("reset_req_ready", req_ready, 1);

      // Write then read back adr 0.
      applyStimulus(1'b1, 3'd0, 8'h55);
      pat = '0;
      repeat (4) begin
         @(posedge clk);
         #1;
         pat = {pat[5:0], op, select};
      end
      checkOutput("t1_write_pattern", pat, 8'b11_11_00_00);
      idle(4);
      applyStimulus(1'b0, 3'd0, 8'h00);
      waitRsp(20, lat);
      checkOutput("t1_read_latency", lat, 3);
      checkOutput("t1_rsp_data", rsp_data, 8'h55);
      checkOutput("t1_rsp_adr", rsp_adr, 3'd0);
      consumeResponse();
      idle(6);

      // Three back-to-back writes.
      base = op_cycles;
      applyStimulus(1'b1, 3'd1, 8'h11);
      applyStimulus(1'b1, 3'd2, 8'h22);
      applyStimulus(1'b1, 3'd3, 8'h33);
      checkOutput("t2_ready_full", req_ready, 0);
      idle(20);
      checkOutput("t2_write_cycles", op_cycles - base, 3 * WR_HOLD);
      checkOutput("t2_ready_again", req_ready, 1);

      // Read stall behind an unconsumed response.
      applyStimulus(1'b1, 3'd5, 8'h5A);
      idle(6);
      applyStimulus(1'b0, 3'd3, 8'h00);
      applyStimulus(1'b0, 3'd5, 8'h00);
      idle(10);
      checkOutput("t3_stall_select", select, 0);
      checkOutput("t3_first_valid", rsp_valid, 1);
      checkOutput("t3_first_data", rsp_data, 8'h33);
      checkOutput("t3_first_adr", rsp_adr, 3'd3);
      consumeResponse();
      waitRsp(20, lat);
      checkOutput("t3_second_data", rsp_data, 8'h5A);
      checkOutput("t3_second_adr", rsp_adr, 3'd5);
      consumeResponse();
      idle(6);

      // mem_valid low during a write sets the sticky error.
      checkOutput("t4_err_before", err, 0);
      mem_valid = 1'b0;
      applyStimulus(1'b1, 3'd7, 8'h77);
      idle(8);
      checkOutput("t4_err_set", err, 1);
      mem_valid = 1'b1;
      applyStimulus(1'b1, 3'd6, 8'h66);
      applyStimulus(1'b0, 3'd6, 8'h00);
      waitRsp(30, lat);
      checkOutput("t4_rsp_data", rsp_data, 8'h66);
      checkOutput("t4_err_sticky", err, 1);
      consumeResponse();
      idle(6);

      // Reset in the middle of a read with two requests queued.
      applyStimulus(1'b0, 3'd1, 8'h00);
      applyStimulus(1'b0, 3'd2, 8'h00);
      applyStimulus(1'b0, 3'd3, 8'h00);
      checkOutput("t5_mid_read_select", select, 1);
      checkOutput("t5_queue_full", req_ready, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_op", op, 0);
      checkOutput("t5_rst_select", select, 0);
      checkOutput("t5_rst_rsp_valid", rsp_valid, 0);
      checkOutput("t5_rst_adr", adr, 3'd0);
      checkOutput("t5_rst_err", err, 0);
      idle(2);
      rst_n = 1'b1;
      rsp_seen = 0;
      sel_seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (rsp_valid) rsp_seen++;
         if (select) sel_seen++;
      end
      @(negedge clk);
      checkOutput("t5_no_response", rsp_seen, 0);
      checkOutput("t5_no_access", sel_seen, 0);
      checkOutput("t5_ready", req_ready, 1);

      // Pointer wrap-around followed by write/read of adr 7.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 3'(i), 8'hA0 + 8'(i));
      end
      applyStimulus(1'b1, 3'd7, 8'hAA);
      applyStimulus(1'b0, 3'd7, 8'h00);
      waitRsp(100, lat);
      checkOutput("t6_rsp_data", rsp_data, 8'hAA);
      checkOutput("t6_rsp_adr", rsp_adr, 3'd7);
      checkOutput("t6_err", err, 0);
      consumeResponse();
      idle(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
